// File: rtl/pong_pkg.sv
// Shared constants and types for the pong video pipeline.
// Holds display geometry, colours, object geometry, ball-centre constants and
// the 2-bit FSM encoding used by the pixel engine. The timing generator and the
// score block use the same package.
package pong_pkg;

    // Display geometry
    localparam logic [9:0] H_DISPLAY = 10'd640;
    localparam logic [9:0] V_DISPLAY = 10'd480;

    // Left wall
    localparam logic [9:0] WALL_L = 10'd32;
    localparam logic [9:0] WALL_R = 10'd35;

    // Paddle
    localparam logic [9:0] PAD_X     = 10'd600;
    localparam logic [9:0] PAD_W     = 10'd4;
    localparam logic [9:0] PAD_H     = 10'd72;
    localparam logic [9:0] PAD_V     = 10'd4;
    localparam logic [9:0] PAD_Y_MAX = 10'd408;  // V_DISPLAY - PAD_H
    localparam logic [9:0] PAD_Y0    = 10'd204;  // (V_DISPLAY - PAD_H) / 2

    // Ball
    localparam logic [9:0] BALL_SZ  = 10'd8;
    localparam logic [9:0] BALL_V   = 10'd2;
    localparam logic [9:0] BALL_X0  = 10'd316;
    localparam logic [9:0] BALL_Y0  = 10'd236;
    localparam logic [5:0] SERVE_FR = 6'd60;

    // Colours {R4,G4,B4}
    localparam logic [11:0] COL_WALL = 12'h00F;
    localparam logic [11:0] COL_PAD  = 12'h0F0;
    localparam logic [11:0] COL_BALL = 12'hF00;
    localparam logic [11:0] COL_BG   = 12'h000;

    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_MISS  = 2'b10
    } state_t;

    // Inclusive range test on 10-bit screen coordinates.
    function automatic logic in_span(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_ball_rom.sv
// 8x8 round-ball bitmap.
// Ports:
//   row   in  3  row inside the ball box (y - ball top)
//   col   in  3  column inside the ball box (x - ball left)
//   pixel out 1  1 where the ball is drawn
module pong_ball_rom (
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [7:0] row_bits_s;

    // Bitmap lookup; bit 7 is the leftmost column.
    always_comb begin
        row_bits_s = 8'b0000_0000;
        case (row)
            3'd0:    row_bits_s = 8'b0011_1100;
            3'd1:    row_bits_s = 8'b0111_1110;
            3'd2:    row_bits_s = 8'b1111_1111;
            3'd3:    row_bits_s = 8'b1111_1111;
            3'd4:    row_bits_s = 8'b1111_1111;
            3'd5:    row_bits_s = 8'b1111_1111;
            3'd6:    row_bits_s = 8'b0111_1110;
            3'd7:    row_bits_s = 8'b0011_1100;
            default: row_bits_s = 8'b0000_0000;
        endcase
        pixel = row_bits_s[3'd7 - col];
    end

endmodule

// File: rtl/pong_pixel_engine.sv
// Game-object and pixel-colour stage behind the VGA timing generator.
// Object state (ball, paddle, FSM) advances once per frame on refresh_tick;
// the colour path is registered every clk for one-clk latency from x/y.
// Ports:
//   clk      in  1   system clock
//   reset    in  1   synchronous active-low reset
//   p_tick   in  1   pixel-enable strobe
//   video_on in  1   visible-area flag
//   x, y     in  10  current pixel column / row
//   btn_up   in  1   paddle up (level)
//   btn_dn   in  1   paddle down (level)
//   rgb      out 12  registered pixel colour
//   hit      out 1   one-clk pulse on paddle bounce
//   miss     out 1   one-clk pulse when the ball passes the paddle
module pong_pixel_engine
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [11:0] rgb,
    output logic        hit,
    output logic        miss
);

    state_t      state_r, state_nxt_s;
    logic [9:0]  bx_r, bx_nxt_s;
    logic [9:0]  by_r, by_nxt_s;
    logic        dx_r, dx_nxt_s;      // 1 = moving right
    logic        dy_r, dy_nxt_s;      // 1 = moving down
    logic [5:0]  serve_cnt_r, serve_cnt_nxt_s;
    logic [9:0]  pad_y_r, pad_y_nxt_s;
    logic        hit_r, hit_nxt_s;
    logic        miss_r, miss_nxt_s;
    logic [11:0] rgb_r, colour_s;

    logic refresh_s;
    logic pad_hit_s;
    logic ndx_s, ndy_s;
    logic wall_px_s, pad_px_s, ball_box_s, ball_bit_s;

    // Once-per-frame strobe: first pixel of the first blanked line.
    assign refresh_s = p_tick && (x == 10'd0) && (y == V_DISPLAY);

    // Ball overlaps the paddle column and rows while travelling right.
    assign pad_hit_s = (bx_r + BALL_SZ - 10'd1 >= PAD_X)
                    && (bx_r <= PAD_X + PAD_W - 10'd1)
                    && (by_r + BALL_SZ - 10'd1 >= pad_y_r)
                    && (by_r <= pad_y_r + PAD_H - 10'd1)
                    && dx_r;

    // New ball direction from the current position; axes are independent.
    always_comb begin
        ndx_s = dx_r;
        ndy_s = dy_r;
        if (pad_hit_s) begin
            ndx_s = 1'b0;
        end else if (bx_r <= WALL_R + 10'd1) begin
            ndx_s = 1'b1;
        end else begin
            ndx_s = dx_r;
        end
        if (by_r <= BALL_V) begin
            ndy_s = 1'b1;
        end else if (by_r + BALL_SZ >= V_DISPLAY - BALL_V) begin
            ndy_s = 1'b0;
        end else begin
            ndy_s = dy_r;
        end
    end

    // Paddle movement with clamping; opposing buttons cancel.
    always_comb begin
        pad_y_nxt_s = pad_y_r;
        if (refresh_s && btn_up && !btn_dn) begin
            pad_y_nxt_s = (pad_y_r >= PAD_V) ? (pad_y_r - PAD_V) : 10'd0;
        end else if (refresh_s && btn_dn && !btn_up) begin
            pad_y_nxt_s = (pad_y_r > PAD_Y_MAX - PAD_V) ? PAD_Y_MAX : (pad_y_r + PAD_V);
        end else begin
            pad_y_nxt_s = pad_y_r;
        end
    end

    // Game FSM next-state and ball update.
    always_comb begin
        state_nxt_s     = state_r;
        bx_nxt_s        = bx_r;
        by_nxt_s        = by_r;
        dx_nxt_s        = dx_r;
        dy_nxt_s        = dy_r;
        serve_cnt_nxt_s = serve_cnt_r;
        hit_nxt_s       = 1'b0;
        miss_nxt_s      = 1'b0;
        case (state_r)
            ST_SERVE: begin
                if (refresh_s && (serve_cnt_r == SERVE_FR - 6'd1)) begin
                    serve_cnt_nxt_s = 6'd0;
                    dx_nxt_s        = 1'b1;
                    state_nxt_s     = ST_PLAY;
                end else if (refresh_s) begin
                    serve_cnt_nxt_s = serve_cnt_r + 6'd1;
                end else begin
                    serve_cnt_nxt_s = serve_cnt_r;
                end
            end
            ST_PLAY: begin
                if (refresh_s && (bx_r > PAD_X + PAD_W - 10'd1)) begin
                    // Ball is past the paddle: freeze it for the MISS frame.
                    state_nxt_s = ST_MISS;
                    miss_nxt_s  = 1'b1;
                end else if (refresh_s) begin
                    dx_nxt_s  = ndx_s;
                    dy_nxt_s  = ndy_s;
                    hit_nxt_s = pad_hit_s;
                    bx_nxt_s  = ndx_s ? (bx_r + BALL_V) : (bx_r - BALL_V);
                    by_nxt_s  = ndy_s ? (by_r + BALL_V) : (by_r - BALL_V);
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_MISS: begin
                if (refresh_s) begin
                    bx_nxt_s        = BALL_X0;
                    by_nxt_s        = BALL_Y0;
                    serve_cnt_nxt_s = 6'd0;
                    state_nxt_s     = ST_SERVE;
                end else begin
                    state_nxt_s = ST_MISS;
                end
            end
            default: begin
                bx_nxt_s        = BALL_X0;
                by_nxt_s        = BALL_Y0;
                serve_cnt_nxt_s = 6'd0;
                state_nxt_s     = ST_SERVE;
            end
        endcase
    end

    // Ball ROM indices: low 3 bits of the offset inside the ball box.
    pong_ball_rom u_ball_rom (
        .row   (y[2:0] - by_r[2:0]),
        .col   (x[2:0] - bx_r[2:0]),
        .pixel (ball_bit_s)
    );

    assign wall_px_s  = in_span(x, WALL_L, WALL_R);
    assign pad_px_s   = in_span(x, PAD_X, PAD_X + PAD_W - 10'd1)
                     && in_span(y, pad_y_r, pad_y_r + PAD_H - 10'd1);
    assign ball_box_s = in_span(x, bx_r, bx_r + BALL_SZ - 10'd1)
                     && in_span(y, by_r, by_r + BALL_SZ - 10'd1);

    // Colour priority: wall, paddle, ball, background; blank outside video.
    always_comb begin
        colour_s = COL_BG;
        if (!video_on) begin
            colour_s = COL_BG;
        end else if (wall_px_s) begin
            colour_s = COL_WALL;
        end else if (pad_px_s) begin
            colour_s = COL_PAD;
        end else if (ball_box_s && ball_bit_s) begin
            colour_s = COL_BALL;
        end else begin
            colour_s = COL_BG;
        end
    end

    // State, object and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_SERVE;
            bx_r        <= BALL_X0;
            by_r        <= BALL_Y0;
            dx_r        <= 1'b1;
            dy_r        <= 1'b1;
            serve_cnt_r <= 6'd0;
            pad_y_r     <= PAD_Y0;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            rgb_r       <= 12'h000;
        end else begin
            state_r     <= state_nxt_s;
            bx_r        <= bx_nxt_s;
            by_r        <= by_nxt_s;
            dx_r        <= dx_nxt_s;
            dy_r        <= dy_nxt_s;
            serve_cnt_r <= serve_cnt_nxt_s;
            pad_y_r     <= pad_y_nxt_s;
            hit_r       <= hit_nxt_s;
            miss_r      <= miss_nxt_s;
            rgb_r       <= colour_s;
        end
    end

    assign rgb  = rgb_r;
    assign hit  = hit_r;
    assign miss = miss_r;

endmodule

// File: tb/tb_pong_pixel_engine.sv
// Directed self-checking bench for pong_pixel_engine. Frames are produced by
// pulsing the refresh condition directly; object state is observed
// hierarchically and compared with hand-computed trajectories.
module tb_pong_pixel_engine;
    import pong_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic [11:0] rgb;
    logic        hit;
    logic        miss;

    int checks = 0;
    int errors = 0;

    pong_pixel_engine dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .btn_up(btn_up), .btn_dn(btn_dn),
        .rgb(rgb), .hit(hit), .miss(miss)
    );

    always #5 clk = ~clk;

    // One refresh_tick; returns hit/miss on the tick clk and on the clk after.
    task automatic do_tick(output logic h, output logic m, output logic ha, output logic ma);
        @(negedge clk); x = 10'd0; y = 10'd480; p_tick = 1'b1; video_on = 1'b0;
        @(negedge clk); h = hit; m = miss; p_tick = 1'b0; x = 10'd1;
        @(negedge clk); ha = hit; ma = miss;
    endtask

    task automatic run_ticks(input int n, output int hits_seen, output int misses_seen);
        logic h, m, ha, ma;
        hits_seen = 0; misses_seen = 0;
        for (int i = 0; i < n; i++) begin
            do_tick(h, m, ha, ma);
            if (h !== 1'b0 || ha !== 1'b0) hits_seen++;
            if (m !== 1'b0 || ma !== 1'b0) misses_seen++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        // Mid-frame on a wall pixel: rgb would be 00F without reset.
        @(negedge clk); reset = 1'b0; x = 10'd33; y = 10'd100; video_on = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", hit); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b exp 0", miss); end
        checks++; if (dut.bx_r !== 10'd316) begin errors++; $display("FAIL reset_bx got %0d exp 316", dut.bx_r); end
        checks++; if (dut.by_r !== 10'd236) begin errors++; $display("FAIL reset_by got %0d exp 236", dut.by_r); end
        checks++; if (dut.pad_y_r !== 10'd204) begin errors++; $display("FAIL reset_pad got %0d exp 204", dut.pad_y_r); end
        checks++; if (dut.state_r !== ST_SERVE) begin errors++; $display("FAIL reset_state got %0d exp 0", dut.state_r); end
        checks++; if (dut.serve_cnt_r !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.serve_cnt_r); end
        checks++; if ({dut.dx_r, dut.dy_r} !== 2'b11) begin errors++; $display("FAIL reset_dir got %b exp 11", {dut.dx_r, dut.dy_r}); end
        reset = 1'b1;
    endtask

    task automatic test_serve();
        int hs, ms;
        run_ticks(59, hs, ms);
        checks++; if (dut.state_r !== ST_SERVE) begin errors++; $display("FAIL serve59_state got %0d exp 0", dut.state_r); end
        checks++; if (dut.serve_cnt_r !== 6'd59) begin errors++; $display("FAIL serve59_cnt got %0d exp 59", dut.serve_cnt_r); end
        run_ticks(1, hs, ms);
        checks++; if (dut.state_r !== ST_PLAY) begin errors++; $display("FAIL serve60_state got %0d exp 1", dut.state_r); end
        checks++; if ({dut.bx_r, dut.by_r} !== {10'd316, 10'd236}) begin errors++; $display("FAIL serve60_pos got %0d,%0d exp 316,236", dut.bx_r, dut.by_r); end
        run_ticks(1, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r} !== {10'd318, 10'd238}) begin errors++; $display("FAIL play1_pos got %0d,%0d exp 318,238", dut.bx_r, dut.by_r); end
    endtask

    task automatic test_paddle();
        int hs, ms;
        pulse_reset();
        btn_up = 1'b1;
        run_ticks(1, hs, ms);
        checks++; if (dut.pad_y_r !== 10'd200) begin errors++; $display("FAIL pad_up1 got %0d exp 200", dut.pad_y_r); end
        run_ticks(50, hs, ms);
        checks++; if (dut.pad_y_r !== 10'd0) begin errors++; $display("FAIL pad_up51 got %0d exp 0", dut.pad_y_r); end
        run_ticks(9, hs, ms);
        checks++; if (dut.pad_y_r !== 10'd0) begin errors++; $display("FAIL pad_up_clamp got %0d exp 0", dut.pad_y_r); end
        btn_up = 1'b0; btn_dn = 1'b1;
        run_ticks(1, hs, ms);
        checks++; if (dut.pad_y_r !== 10'd4) begin errors++; $display("FAIL pad_dn1 got %0d exp 4", dut.pad_y_r); end
        btn_up = 1'b1;
        run_ticks(2, hs, ms);
        checks++; if (dut.pad_y_r !== 10'd4) begin errors++; $display("FAIL pad_both got %0d exp 4", dut.pad_y_r); end
        btn_up = 1'b0; btn_dn = 1'b0;
    endtask

    task automatic test_hit();
        int hs, ms;
        logic h, m, ha, ma;
        pulse_reset();
        btn_dn = 1'b1;
        run_ticks(60, hs, ms);
        btn_dn = 1'b0;
        checks++; if (dut.pad_y_r !== 10'd408) begin errors++; $display("FAIL pad_dn_clamp got %0d exp 408", dut.pad_y_r); end
        run_ticks(139, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r} !== {10'd594, 10'd426}) begin errors++; $display("FAIL prehit_pos got %0d,%0d exp 594,426", dut.bx_r, dut.by_r); end
        checks++; if (hs != 0) begin errors++; $display("FAIL prehit_hits got %0d exp 0", hs); end
        do_tick(h, m, ha, ma);
        checks++; if ({h, ha} !== 2'b10) begin errors++; $display("FAIL hit_pulse got %b exp 10", {h, ha}); end
        checks++; if ({dut.bx_r, dut.by_r, dut.dx_r} !== {10'd592, 10'd424, 1'b0}) begin errors++; $display("FAIL hit_pos got %0d,%0d dx %b exp 592,424 dx 0", dut.bx_r, dut.by_r, dut.dx_r); end
    endtask

    task automatic test_wall_corner();
        int hs, ms;
        run_ticks(211, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r} !== {10'd170, 10'd2}) begin errors++; $display("FAIL top_pos got %0d,%0d exp 170,2", dut.bx_r, dut.by_r); end
        run_ticks(1, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r, dut.dy_r} !== {10'd168, 10'd4, 1'b1}) begin errors++; $display("FAIL top_bounce got %0d,%0d dy %b exp 168,4 dy 1", dut.bx_r, dut.by_r, dut.dy_r); end
        run_ticks(66, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r} !== {10'd36, 10'd136}) begin errors++; $display("FAIL wall_pos got %0d,%0d exp 36,136", dut.bx_r, dut.by_r); end
        run_ticks(1, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r, dut.dx_r} !== {10'd38, 10'd138, 1'b1}) begin errors++; $display("FAIL wall_bounce got %0d,%0d dx %b exp 38,138 dx 1", dut.bx_r, dut.by_r, dut.dx_r); end
        checks++; if (hs != 0) begin errors++; $display("FAIL wall_hits got %0d exp 0", hs); end
    endtask

    task automatic test_miss();
        int hs, ms;
        logic h, m, ha, ma;
        pulse_reset();
        btn_up = 1'b1;
        run_ticks(60, hs, ms);
        btn_up = 1'b0;
        run_ticks(144, hs, ms);
        checks++; if ({dut.bx_r, dut.by_r} !== {10'd604, 10'd416}) begin errors++; $display("FAIL premiss_pos got %0d,%0d exp 604,416", dut.bx_r, dut.by_r); end
        checks++; if (hs + ms != 0) begin errors++; $display("FAIL premiss_pulses got %0d exp 0", hs + ms); end
        do_tick(h, m, ha, ma);
        checks++; if ({m, ma} !== 2'b10) begin errors++; $display("FAIL miss_pulse got %b exp 10", {m, ma}); end
        checks++; if (dut.state_r !== ST_MISS || dut.bx_r !== 10'd604) begin errors++; $display("FAIL miss_state got %0d bx %0d exp 2 bx 604", dut.state_r, dut.bx_r); end
        do_tick(h, m, ha, ma);
        checks++; if ({m, ma} !== 2'b00) begin errors++; $display("FAIL miss_once got %b exp 00", {m, ma}); end
        checks++; if (dut.state_r !== ST_SERVE || {dut.bx_r, dut.by_r} !== {10'd316, 10'd236}) begin errors++; $display("FAIL reserve got %0d %0d,%0d exp 0 316,236", dut.state_r, dut.bx_r, dut.by_r); end
    endtask

    task automatic test_pixel();
        logic [9:0]  px [10];
        logic [9:0]  py [10];
        logic        pv [10];
        logic [11:0] pe [10];
        pulse_reset();
        px = '{10'd33,  10'd700, 10'd316, 10'd319, 10'd601, 10'd601, 10'd601, 10'd601, 10'd35,  10'd36};
        py = '{10'd100, 10'd100, 10'd236, 10'd239, 10'd204, 10'd203, 10'd275, 10'd276, 10'd300, 10'd300};
        pv = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};
        pe = '{12'h00F, 12'h000, 12'h000, 12'hF00, 12'h0F0, 12'h000, 12'h0F0, 12'h000, 12'h00F, 12'h000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); x = px[i]; y = py[i]; video_on = pv[i];
            @(negedge clk);
            checks++;
            if (rgb !== pe[i]) begin
                errors++;
                $display("FAIL pixel_%0d (%0d,%0d) got %h exp %h", i, px[i], py[i], rgb, pe[i]);
            end
        end
        video_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle();
        test_hit();
        test_wall_corner();
        test_miss();
        test_pixel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
